uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Hardware UART receiver with a receive FIFO. It replaces the polled, bit-banged serial input on the io processor's bus. The block oversamples the rx line, frames 8N1 bytes LSB-first, and queues them. The io processor reads status and data through a two-register window on its memory bus. It is the receive-side counterpart of the software-driven tx path and sits in the io_clk domain next to the io register decode.

Parameters:
DIVISOR, 723, io_clk cycles per bit (83.333 MHz / 115200 baud, rounded); must be >= 8
DEPTH, 16, FIFO entries; power of two, >= 2

Ports:
clk  in  1  io_clk; all state is on the rising edge
reset_n  in  1  asynchronous, active-low reset
rxd  in  1  raw serial input; asynchronous, idle high
bus_read  in  1  read strobe from the io processor
bus_write  in  1  write strobe from the io processor
bus_address  in  1  register select: 0 = status, 1 = data
bus_D  in  8  write data
bus_Q  out  8  registered read data
rx_nonempty  out  1  FIFO holds at least one byte

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; FIFO is empty; ovr and ferr are 0.
  - bus_Q = 0x00, rx_nonempty = 0.
  - The synchronizer presets to 1.
- Input synchronizer: 2 flops, giving rxs. Edge detect uses rxs and its previous value.
- FSM states: IDLE, START, DATA, STOP, BREAK. A counter cnt reloads at each state entry; HALF = DIVISOR/2 (integer division).
- IDLE: a falling edge on rxs (1 to 0) goes to START with cnt = HALF-1.
- START: when cnt reaches 0, sample rxs.
  - 0: go to DATA with cnt = DIVISOR-1 and bit index 0.
  - 1: this is a glitch; return to IDLE with no flag set.
- DATA: at each cnt==0, shift rxs into bit[index], LSB first, and reload cnt. After index 7 is sampled, go to STOP with cnt = DIVISOR-1.
- STOP: when cnt reaches 0, sample rxs.
  - 1: push the byte and go to IDLE. The next start edge is accepted from the following cycle.
  - 0: set ferr, discard the byte, and go to BREAK.
- BREAK: stay until rxs == 1, then go to IDLE. No edge is needed to leave.
- Sample point: mid-bit, i.e. HALF + k*DIVISOR cycles after the synchronized falling edge, k = 0..9.
- FIFO: DEPTH entries with wrap-around pointers plus a count.
  - Push when full: drop the byte and set ovr (sticky). FIFO contents are unchanged.
  - Push and pop in the same cycle: always allowed, including when full (no ovr) and when empty with a pop (the pop returns 0x00, the push is stored).
- Bus read: 1-cycle latency. bus_Q updates on the edge after bus_read.
  - bus_read = 0: bus_Q = 0x00.
  - Address 0: bus_Q = {5'b0, ferr, ovr, rx_nonempty}.
  - Address 1, FIFO non-empty: bus_Q = head byte and the FIFO pops.
  - Address 1, FIFO empty: bus_Q = 0x00, no pop, no error.
- Bus write:
  - Address 0: bit1 = 1 clears ovr; bit2 = 1 clears ferr. Other bits are ignored.
  - Address 1: ignored.
  - A flag set and a clear in the same cycle: set wins.
- Simultaneous read and write: both take effect. A status read returns flag values from before the write.
- rx_nonempty is registered and reflects the FIFO count after the current cycle's push/pop.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum rx_state_t {IDLE, START, DATA, STOP, BREAK};
  - register address constants UART_STATUS = 0 and UART_DATA = 1;
  - status bit indices NONEMPTY = 0, OVR = 1, FERR = 2.
- Sub-module sync_fifo (parameter WIDTH, DEPTH; ports push, pop, din, dout, full, empty). It shows first-word-fall-through dout and includes the simultaneous push/pop rule.
- The top level contains the synchronizer, FSM, flags and bus decode.

Test Plan:
- Run all tests with DIVISOR=16, DEPTH=4.
- Send byte 0xA5 (8N1) at 16 cycles/bit. Then read address 1 → bus_Q = 0xA5 one cycle later. Status before the read = 0x01; after = 0x00.
- Apply a 3-cycle low pulse on rxd → no byte is queued, ferr = 0, and the FSM is back in IDLE. Then send 0x3C → reads back 0x3C.
- Send 0x55 with the stop bit held low for 40 cycles → status = 0x04 and the FIFO stays empty. Write 0x04 to address 0 → status = 0x00. Then 0x12 is received correctly.
- Send 5 bytes 0x01..0x05 with no reads → status = 0x03. Reads return 0x01..0x04, then 0x00 with status 0x02.
- With the FIFO full, issue a data read in the stop-sample cycle of byte 0x77 → no ovr. 0x77 becomes the last entry.
- Assert reset_n low in the middle of the DATA state → bus_Q = 0, rx_nonempty = 0, FIFO empty. After release, byte 0x9E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path and its register window.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam logic UART_STATUS = 1'b0;
  localparam logic UART_DATA   = 1'b1;

  localparam int NONEMPTY = 0;
  localparam int OVR      = 1;
  localparam int FERR     = 2;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW:0]      w_count_nxt;

  assign w_do_pop  = pop & ~r_empty;
  assign w_do_push = push & (~r_full | w_do_pop);
  assign full      = r_full;
  assign empty     = r_empty;

  // Next occupancy, used so full/empty can be registered
  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Head byte, forced to zero while empty
  always_comb begin
    if (r_empty) begin
      dout = '0;
    end else begin
      dout = r_mem[r_rd_ptr];
    end
  end

  // Storage array
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers, count and registered flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == (AW+1)'(0));
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, a receive FIFO and a status/data bus window.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DIVISOR = 723,
  parameter int DEPTH   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  input  logic       bus_read,
  input  logic       bus_write,
  input  logic       bus_address,
  input  logic [7:0] bus_D,
  output logic [7:0] bus_Q,
  output logic       rx_nonempty
);

  localparam int CW   = $clog2(DIVISOR);
  localparam int HALF = DIVISOR / 2;
  localparam logic [CW-1:0] CNT_BIT  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  logic       r_rst_meta, r_rst_sync;
  logic       r_sync1, r_rxs, r_rxs_prev;
  rx_state_t  r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_ovr, r_ferr;
  logic [7:0] r_bus_q, w_bus_q_nxt, w_status;
  logic       w_push, w_pop, w_ferr_set;
  logic       w_full, w_empty;
  logic [7:0] w_dout;
  logic       w_tick, w_fall, w_clr_ovr, w_clr_ferr, w_ovr_set;
  logic       w_unused_bus_d;

  assign w_tick     = (r_cnt == CW'(0));
  assign w_fall     = r_rxs_prev & ~r_rxs;
  assign w_pop      = bus_read & (bus_address == UART_DATA) & ~w_empty;
  assign w_ovr_set  = w_push & w_full & ~w_pop;
  assign w_clr_ovr  = bus_write & (bus_address == UART_STATUS) & bus_D[OVR];
  assign w_clr_ferr = bus_write & (bus_address == UART_STATUS) & bus_D[FERR];
  assign w_unused_bus_d = ^{bus_D[7:3], bus_D[0]};
  assign bus_Q       = r_bus_q;
  assign rx_nonempty = ~w_empty;

  // Reset synchronizer: asserts immediately, releases on the clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  // Receive framing state machine
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = START;
          w_cnt_nxt   = CNT_HALF;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (!r_rxs) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = CNT_BIT;
          w_idx_nxt   = 3'd0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DATA: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_shift_nxt[r_idx] = r_rxs;
          w_cnt_nxt          = CNT_BIT;
          if (r_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (r_rxs) begin
          w_push      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_ferr_set  = 1'b1;
          w_state_nxt = BREAK;
        end
      end
      BREAK: begin
        if (r_rxs) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BREAK;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status word; flags read back as they were before any same-cycle write
  always_comb begin
    w_status           = 8'h00;
    w_status[NONEMPTY] = ~w_empty;
    w_status[OVR]      = r_ovr;
    w_status[FERR]     = r_ferr;
  end

  // Read data for the next cycle
  always_comb begin
    if (!bus_read) begin
      w_bus_q_nxt = 8'h00;
    end else if (bus_address == UART_STATUS) begin
      w_bus_q_nxt = w_status;
    end else begin
      w_bus_q_nxt = w_dout;
    end
  end

  // Synchronizer, FSM registers, sticky flags and read data
  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_sync1    <= 1'b1;
      r_rxs      <= 1'b1;
      r_rxs_prev <= 1'b1;
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= 3'd0;
      r_shift    <= 8'h00;
      r_ovr      <= 1'b0;
      r_ferr     <= 1'b0;
      r_bus_q    <= 8'h00;
    end else begin
      r_sync1    <= rxd;
      r_rxs      <= r_sync1;
      r_rxs_prev <= r_rxs;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_ovr      <= w_ovr_set  | (r_ovr  & ~w_clr_ovr);
      r_ferr     <= w_ferr_set | (r_ferr & ~w_clr_ferr);
      r_bus_q    <= w_bus_q_nxt;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (r_rst_sync),
    .push    (w_push),
    .pop     (w_pop),
    .din     (r_shift),
    .dout    (w_dout),
    .full    (w_full),
    .empty   (w_empty)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic       bus_read = 1'b0;
  logic       bus_write = 1'b0;
  logic       bus_address = 1'b0;
  logic [7:0] bus_D = 8'h00;
  logic [7:0] bus_Q;
  logic       rx_nonempty;
  int         total = 0;
  int         bad = 0;
  logic [7:0] q;

  uart_rx_fifo #(.DIVISOR(16), .DEPTH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rxd         (rxd),
    .bus_read    (bus_read),
    .bus_write   (bus_write),
    .bus_address (bus_address),
    .bus_D       (bus_D),
    .bus_Q       (bus_Q),
    .rx_nonempty (rx_nonempty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic bus_rd(input logic a, output logic [7:0] d);
    @(negedge clk);
    bus_read = 1'b1;
    bus_address = a;
    @(negedge clk);
    bus_read = 1'b0;
    d = bus_Q;
  endtask

  task automatic bus_wr(input logic a, input logic [7:0] d);
    @(negedge clk);
    bus_write = 1'b1;
    bus_address = a;
    bus_D = d;
    @(negedge clk);
    bus_write = 1'b0;
    bus_D = 8'h00;
  endtask

  // Frame one 8N1 byte; optionally hold the stop bit low, or read data in the stop-sample cycle
  task automatic send_byte(input logic [7:0] b, input int stop_low, input bit rd_stop,
                           output logic [7:0] rd_val);
    rd_val = 8'h00;
    for (int n = 0; n < 160 + stop_low; n++) begin
      @(negedge clk);
      if (n < 16) rxd = 1'b0;
      else if (n < 144) rxd = b[(n - 16) / 16];
      else if (n < 144 + stop_low) rxd = 1'b0;
      else rxd = 1'b1;
      if (rd_stop && n == 154) begin
        bus_read = 1'b1;
        bus_address = UART_DATA;
      end else if (rd_stop && n == 155) begin
        bus_read = 1'b0;
        rd_val = bus_Q;
      end
    end
    @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_bus_q", bus_Q, 8'h00);
    chk("reset_nonempty", {7'b0, rx_nonempty}, 8'h00);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    bus_rd(UART_STATUS, q); chk("reset_status", q, 8'h00);

    send_byte(8'hA5, 0, 1'b0, q);
    bus_rd(UART_STATUS, q); chk("a5_status_before", q, 8'h01);
    bus_rd(UART_DATA, q);   chk("a5_data", q, 8'hA5);
    bus_rd(UART_STATUS, q); chk("a5_status_after", q, 8'h00);

    @(negedge clk); rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    bus_rd(UART_STATUS, q); chk("glitch_status", q, 8'h00);
    chk("glitch_idle", {5'b0, dut.r_state}, {5'b0, IDLE});
    send_byte(8'h3C, 0, 1'b0, q);
    bus_rd(UART_DATA, q); chk("3c_data", q, 8'h3C);

    send_byte(8'h55, 40, 1'b0, q);
    bus_rd(UART_STATUS, q); chk("ferr_status", q, 8'h04);
    bus_rd(UART_DATA, q);   chk("ferr_fifo_empty", q, 8'h00);
    bus_wr(UART_STATUS, 8'h04);
    bus_rd(UART_STATUS, q); chk("ferr_cleared", q, 8'h00);
    send_byte(8'h12, 0, 1'b0, q);
    bus_rd(UART_DATA, q); chk("12_data", q, 8'h12);

    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 0, 1'b0, q);
    end
    bus_rd(UART_STATUS, q); chk("ovr_status", q, 8'h03);
    for (int i = 1; i <= 4; i++) begin
      bus_rd(UART_DATA, q); chk("ovr_drain", q, 8'(i));
    end
    bus_rd(UART_DATA, q);   chk("ovr_empty_read", q, 8'h00);
    bus_rd(UART_STATUS, q); chk("ovr_sticky", q, 8'h02);
    bus_wr(UART_STATUS, 8'h02);
    bus_rd(UART_STATUS, q); chk("ovr_cleared", q, 8'h00);

    for (int i = 0; i < 4; i++) begin
      send_byte(8'h10 + 8'(i), 0, 1'b0, q);
    end
    bus_rd(UART_STATUS, q); chk("full_status", q, 8'h01);
    send_byte(8'h77, 0, 1'b1, q);
    chk("pushpop_head", q, 8'h10);
    bus_rd(UART_STATUS, q); chk("pushpop_no_ovr", q, 8'h01);
    bus_rd(UART_DATA, q); chk("pushpop_d1", q, 8'h11);
    bus_rd(UART_DATA, q); chk("pushpop_d2", q, 8'h12);
    bus_rd(UART_DATA, q); chk("pushpop_d3", q, 8'h13);
    bus_rd(UART_DATA, q); chk("pushpop_last", q, 8'h77);
    bus_rd(UART_STATUS, q); chk("pushpop_drained", q, 8'h00);

    send_byte(8'h33, 0, 1'b0, q);
    @(negedge clk);
    bus_read = 1'b1;
    bus_address = UART_STATUS;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      rxd = (n < 16) ? 1'b0 : n[4];
    end
    chk("pre_reset_bus_q", bus_Q, 8'h01);
    chk("pre_reset_in_data", {5'b0, dut.r_state}, {5'b0, DATA});
    reset_n = 1'b0;
    #1;
    chk("midreset_bus_q", bus_Q, 8'h00);
    chk("midreset_nonempty", {7'b0, rx_nonempty}, 8'h00);
    bus_read = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    bus_rd(UART_STATUS, q); chk("post_reset_status", q, 8'h00);
    send_byte(8'h9E, 0, 1'b0, q);
    bus_rd(UART_DATA, q);   chk("9e_data", q, 8'h9E);
    bus_rd(UART_STATUS, q); chk("9e_status", q, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
